memoria_de_dados_parametrizada: RTL
===================================

MEMORIA_DE_DADOS_PARAMETRIZADA -- requirements
Module: memoria_de_dados_parametrizada

Interface
REQ-001 SHALL have parameter PALAVRAS_LOG2, default 7, giving a depth of 2**PALAVRAS_LOG2 32-bit words.
REQ-002 SHALL have parameter LATENCIA, default 1, giving wait cycles between request acceptance and access (legal 0..15).
REQ-003 SHALL have port clock, input, 1 bit; the single clock, all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have port sinal_ler, input, 1 bit; load request.
REQ-006 SHALL have port sinal_escrever, input, 1 bit; store request.
REQ-007 SHALL have port tamanho, input, 2 bits; 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 SHALL have port sem_sinal, input, 1 bit; 1 = zero-extend byte/halfword loads, 0 = sign-extend.
REQ-009 SHALL have port endereco, input, PALAVRAS_LOG2+2 bits; byte address.
REQ-010 SHALL have port dado_escrever, input, 32 bits; store data, right-aligned (byte in [7:0], halfword in [15:0]).
REQ-011 SHALL have port dado_ler, output, 32 bits; registered, extended load result.
REQ-012 SHALL have port pronto, output, 1 bit; one-cycle completion pulse.
REQ-013 SHALL have port ocupado, output, 1 bit; high while a request is in flight.
REQ-014 SHALL have port erro_alinhamento, output, 1 bit; valid with pronto, flags rejected request.

Function
REQ-015 SHALL implement FSM states OCIOSO, ESPERA, ACESSO.
REQ-016 In OCIOSO with sinal_ler or sinal_escrever high, SHALL latch tamanho, sem_sinal, endereco, dado_escrever and the operation, and leave OCIOSO next edge.
REQ-017 Simultaneous sinal_ler and sinal_escrever SHALL be accepted as a store only.
REQ-018 Requests while ocupado=1 SHALL be ignored; no queuing.
REQ-019 ocupado SHALL be 1 in ESPERA and ACESSO, 0 in OCIOSO.
REQ-020 After acceptance, SHALL go to ESPERA for exactly LATENCIA cycles (counter), or directly to ACESSO when LATENCIA=0.
REQ-021 ACESSO SHALL last one cycle: perform the access, assert pronto, return to OCIOSO; a request accepted at edge N completes with pronto high in cycle N+1+LATENCIA.
REQ-022 Misaligned requests (halfword with endereco[0]=1, word with endereco[1:0]!=0) or tamanho=11 SHALL skip memory access, complete with normal latency, pronto=1 and erro_alinhamento=1, dado_ler unchanged.
REQ-023 Byte lanes SHALL be little-endian: byte at endereco[1:0]=k occupies word bits [8k+7:8k]; word index = endereco[PALAVRAS_LOG2+1:2].
REQ-024 Stores SHALL write only the addressed lanes (byte: 1 lane, halfword: lanes k,k+1, word: all four); other lanes unchanged.
REQ-025 Loads SHALL extract the addressed lanes to bits [7:0]/[15:0] and extend per sem_sinal; word loads unaffected by sem_sinal.
REQ-026 dado_ler SHALL update only at a successful load completion and hold value otherwise (including after stores and errors).
REQ-027 erro_alinhamento SHALL be 0 whenever pronto is 0.

Reset
REQ-028 reset high at a rising edge SHALL force OCIOSO, counter 0, pronto 0, ocupado 0, erro_alinhamento 0, dado_ler 0x00000000.
REQ-029 reset SHALL take priority over any request that edge; an in-flight request SHALL be discarded with no memory write and no pronto.
REQ-030 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-031 LATENCIA=2: store word 0xDEADBEEF at 0x08, accepted edge N -> pronto only in cycle N+3, ocupado high cycles N+1..N+3; then load word 0x08 -> dado_ler=0xDEADBEEF.
REQ-032 Memory 0x08=0xDEADBEEF: store byte 0x55 at 0x09 -> load word 0x08 returns 0xDEAD55EF; load byte 0x0B sem_sinal=0 -> 0xFFFFFFDE, sem_sinal=1 -> 0x000000DE.
REQ-033 Load halfword 0x0A sem_sinal=0 on 0xDEAD55EF -> 0xFFFFDEAD; load halfword 0x09 -> pronto with erro_alinhamento=1, dado_ler keeps 0xFFFFDEAD, memory unchanged.
REQ-034 sinal_ler and sinal_escrever both high, word 0x11223344 at 0x10 -> stored, dado_ler unchanged; new request pulsed while ocupado -> ignored, exactly one pronto.
REQ-035 reset asserted in ESPERA of store 0xCAFEF00D to 0x20 (previous 0x00000000) -> no pronto, all outputs 0; subsequent load 0x20 returns 0x00000000.
REQ-036 LATENCIA=0: load accepted edge N -> pronto in cycle N+1; back-to-back requests accepted every second cycle.

Source files
------------

// File: rtl/memoria_de_dados_parametrizada.sv
// memoria_de_dados_parametrizada: byte-addressable word memory with configurable access latency and alignment checks
module memoria_de_dados_parametrizada #(
  parameter int PALAVRAS_LOG2 = 7,
  parameter int LATENCIA = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     sinal_ler,
  input  logic                     sinal_escrever,
  input  logic [1:0]               tamanho,
  input  logic                     sem_sinal,
  input  logic [PALAVRAS_LOG2+1:0] endereco,
  input  logic [31:0]              dado_escrever,
  output logic [31:0]              dado_ler,
  output logic                     pronto,
  output logic                     ocupado,
  output logic                     erro_alinhamento
);
  localparam int A = PALAVRAS_LOG2 + 2;
  typedef enum logic [1:0] {OCIOSO, ESPERA, ACESSO} estado_t;
  estado_t r_estado;
  logic [3:0] r_cnt;
  logic r_wr, r_sem;
  logic [1:0] r_tam;
  logic [A-1:0] r_end;
  logic [31:0] r_dado;
  logic [31:0] r_mem [2**PALAVRAS_LOG2];
  logic w_aceita, w_go, w_wr, w_sem, w_err;
  logic [1:0] w_tam, w_k;
  logic [A-1:0] w_end;
  logic [PALAVRAS_LOG2-1:0] w_idx;
  logic [31:0] w_d, w_word, w_load, w_wdata;
  logic [7:0] w_byte;
  logic [15:0] w_half;
  logic [3:0] w_mask;
  // With zero latency the access happens on the acceptance edge, so the raw inputs are used
  always_comb begin
    w_aceita = (r_estado == OCIOSO) && (sinal_ler || sinal_escrever);
    w_go = (w_aceita && (LATENCIA == 0)) || (r_estado == ESPERA && r_cnt == 4'd0);
    w_wr = (r_estado == OCIOSO) ? sinal_escrever : r_wr;
    w_sem = (r_estado == OCIOSO) ? sem_sinal : r_sem;
    w_tam = (r_estado == OCIOSO) ? tamanho : r_tam;
    w_end = (r_estado == OCIOSO) ? endereco : r_end;
    w_d = (r_estado == OCIOSO) ? dado_escrever : r_dado;
    w_k = w_end[1:0];
    w_idx = w_end[A-1:2];
    w_err = (w_tam == 2'b11) || (w_tam == 2'b01 && w_k[0]) || (w_tam == 2'b10 && w_k != 2'b00);
    w_word = r_mem[w_idx];
    w_byte = w_word[{w_k, 3'b000} +: 8];
    w_half = w_word[{w_k[1], 4'b0000} +: 16];
    w_load = (w_tam == 2'b00) ? {{24{~w_sem & w_byte[7]}}, w_byte} :
             (w_tam == 2'b01) ? {{16{~w_sem & w_half[15]}}, w_half} : w_word;
    w_mask = (w_tam == 2'b00) ? 4'b0001 << w_k : (w_tam == 2'b01) ? 4'b0011 << w_k : 4'b1111;
    w_wdata = (w_tam == 2'b00) ? {4{w_d[7:0]}} : (w_tam == 2'b01) ? {2{w_d[15:0]}} : w_d;
  end
  always_ff @(posedge clock)
    if (!reset && w_go && w_wr && !w_err)
      for (int b = 0; b < 4; b++)
        if (w_mask[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
  always_ff @(posedge clock)
    if (reset) begin
      r_estado <= OCIOSO;
      r_cnt <= 4'd0;
      pronto <= 1'b0;
      ocupado <= 1'b0;
      erro_alinhamento <= 1'b0;
      dado_ler <= 32'd0;
    end else begin
      pronto <= 1'b0;
      erro_alinhamento <= 1'b0;
      if (w_aceita) begin
        r_wr <= sinal_escrever;
        r_sem <= sem_sinal;
        r_tam <= tamanho;
        r_end <= endereco;
        r_dado <= dado_escrever;
      end
      if (w_go) begin
        r_estado <= ACESSO;
        ocupado <= 1'b1;
        pronto <= 1'b1;
        erro_alinhamento <= w_err;
        if (!w_wr && !w_err) dado_ler <= w_load;
      end else if (w_aceita) begin
        r_estado <= ESPERA;
        ocupado <= 1'b1;
        r_cnt <= 4'(LATENCIA - 1);
      end else if (r_estado == ESPERA) begin
        r_cnt <= r_cnt - 4'd1;
      end else if (r_estado == ACESSO) begin
        r_estado <= OCIOSO;
        ocupado <= 1'b0;
      end
    end
endmodule
